flit_packet_fifo: RTL and testbench

Parametrised, packet-aware flit buffer; the next-generation replacement for the fixed 5-flit write-only FIFO in the Flitzip datapath. It sits between the compressor/decompressor stages and the router port. It buffers up to DEPTH flits with valid/ready handshakes on both sides, tracks packet boundaries through a tail flag, and reports occupancy, almost-full and complete-packet availability.

---
 rtl/flit_fifo_pkg.sv | 27 ++
 rtl/flit_fifo_ptr.sv | 49 ++++
 rtl/flit_packet_fifo.sv | 138 +++++++++++++
 tb/tb_flit_packet_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/flit_fifo_pkg.sv
// ---------------------------------------------------------------------------
// flit_fifo_pkg
// Shared types and width helpers for the packet-aware flit FIFO.
//   flit_t   : one buffered flit (payload + tail flag) at the default width
//   level_w  : bits needed to hold an occupancy count of 0..depth
//   ptr_w    : bits needed to index 0..depth-1
// ---------------------------------------------------------------------------
package flit_fifo_pkg;

    localparam int unsigned FLIT_DATA_W = 32'd128;

    typedef struct packed {
        logic [FLIT_DATA_W-1:0] data;
        logic                   last;
    } flit_t;

    // Occupancy counter width: must represent the value depth itself.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // Pointer width, never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 32'd2) ? 32'd1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/flit_fifo_ptr.sv
// ---------------------------------------------------------------------------
// flit_fifo_ptr
// Index pointer that advances on inc_en and wraps from DEPTH-1 back to 0.
// The wrap is an explicit compare, so non-power-of-two depths work.
// Ports:
//   clk_in   : clock
//   rst_n_in : asynchronous active-low reset (pointer -> 0)
//   inc_en   : advance the pointer on this edge
//   ptr      : current pointer value (registered)
// ---------------------------------------------------------------------------
module flit_fifo_ptr
    import flit_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd5,
    parameter int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             inc_en,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;

    // Next pointer: hold, increment, or wrap to zero after the last entry.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (!inc_en) begin
            ptr_nxt_s = ptr_r;
        end else if (ptr_r == PTR_W'(DEPTH - 32'd1)) begin
            ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            ptr_nxt_s = ptr_r + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_r <= {PTR_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/flit_packet_fifo.sv
// ---------------------------------------------------------------------------
// flit_packet_fifo
// Packet-aware flit buffer with valid/ready on both sides, show-ahead read.
// Optional feature macro: FLIT_FIFO_OVERFLOW_FLAG_EN (sticky err_overflow when
// the producer drives in_valid into a full FIFO; otherwise err_overflow = 0).
// Ports:
//   clk_in, rst_n_in          : clock, asynchronous active-low reset
//   in_valid/in_ready         : write handshake (in_ready = !full)
//   in_data, in_last          : flit payload and packet tail flag
//   out_valid/out_ready       : read handshake (out_valid = !empty)
//   out_data, out_last        : head flit, driven from storage at rd_ptr
//   level                     : number of stored flits
//   almost_full               : level >= AFULL_LEVEL
//   pkt_avail                 : at least one stored tail flit
//   err_overflow              : sticky overflow flag (feature macro)
// All status outputs derive only from registered state.
// ---------------------------------------------------------------------------
module flit_packet_fifo
    import flit_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 32'd128,
    parameter  int unsigned DEPTH       = 32'd5,
    parameter  int unsigned AFULL_LEVEL = DEPTH - 32'd1,
    localparam int unsigned LEVEL_W     = level_w(DEPTH),
    localparam int unsigned PTR_W       = ptr_w(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [LEVEL_W-1:0]    level,
    output logic                  almost_full,
    output logic                  pkt_avail,
    output logic                  err_overflow
);

    logic [DATA_WIDTH-1:0] mem_data_r [DEPTH];
    logic                  mem_last_r [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_s;
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] pkt_count_r;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               pkt_in_s;
    logic               pkt_out_s;

    assign full_s    = (level_r == LEVEL_W'(DEPTH));
    assign empty_s   = (level_r == {LEVEL_W{1'b0}});
    // in_ready looks only at full, so a pop cannot open a slot in the same cycle.
    assign push_s    = in_valid && !full_s;
    assign pop_s     = out_ready && !empty_s;
    assign pkt_in_s  = push_s && in_last;
    assign pkt_out_s = pop_s && mem_last_r[rd_ptr_s];

    flit_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .inc_en   (push_s),
        .ptr      (wr_ptr_s)
    );

    flit_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .inc_en   (pop_s),
        .ptr      (rd_ptr_s)
    );

    // Flit storage; contents are intentionally left unreset.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_data_r[wr_ptr_s] <= in_data;
            mem_last_r[wr_ptr_s] <= in_last;
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            level_r <= {LEVEL_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_W'(1);
                2'b01:   level_r <= level_r - LEVEL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Complete-packet count: tails in minus tails out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pkt_count_r <= {LEVEL_W{1'b0}};
        end else begin
            case ({pkt_in_s, pkt_out_s})
                2'b10:   pkt_count_r <= pkt_count_r + LEVEL_W'(1);
                2'b01:   pkt_count_r <= pkt_count_r - LEVEL_W'(1);
                default: pkt_count_r <= pkt_count_r;
            endcase
        end
    end

`ifdef FLIT_FIFO_OVERFLOW_FLAG_EN
    logic err_overflow_r;

    // Sticky until reset: producer pushed against backpressure.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_overflow_r <= 1'b0;
        end else begin
            err_overflow_r <= err_overflow_r | (in_valid & full_s);
        end
    end

    assign err_overflow = err_overflow_r;
`else
    assign err_overflow = 1'b0;
`endif

    assign in_ready    = !full_s;
    assign out_valid   = !empty_s;
    assign out_data    = mem_data_r[rd_ptr_s];
    assign out_last    = mem_last_r[rd_ptr_s];
    assign level       = level_r;
    assign almost_full = (level_r >= LEVEL_W'(AFULL_LEVEL));
    assign pkt_avail   = (pkt_count_r != {LEVEL_W{1'b0}});

endmodule

// File: tb/tb_flit_packet_fifo.sv
// ---------------------------------------------------------------------------
// tb_flit_packet_fifo
// Scoreboard bench: a queue of expected flits is filled as the producer side
// issues accepted writes; a separate monitor pops and compares whenever the
// DUT completes a read. Status outputs are compared against the queue state.
// ---------------------------------------------------------------------------
module tb_flit_packet_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 5;
    localparam int AFULL = DEPTH - 1;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          pkt_avail;
    logic          err_overflow;

    ent_t exp_q[$];
    logic mdl_err = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    flit_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .level        (level),
        .almost_full  (almost_full),
        .pkt_avail    (pkt_avail),
        .err_overflow (err_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Status checks against the model, then record accepted writes.
    always @(negedge clk_in) begin
        int  sz;
        bit  any_tail;
        if (rst_n_in) begin
            sz = exp_q.size();
            any_tail = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].last) any_tail = 1'b1;
            check("level",        DW'(level),        DW'(sz));
            check("in_ready",     DW'(in_ready),     DW'(sz < DEPTH));
            check("out_valid",    DW'(out_valid),    DW'(sz > 0));
            check("almost_full",  DW'(almost_full),  DW'(sz >= AFULL));
            check("pkt_avail",    DW'(pkt_avail),    DW'(any_tail));
            check("err_overflow", DW'(err_overflow), DW'(mdl_err));
            if (in_valid && sz < DEPTH) begin
                exp_q.push_back('{last: in_last, data: in_data});
            end
`ifdef FLIT_FIFO_OVERFLOW_FLAG_EN
            if (in_valid && sz == DEPTH) mdl_err = 1'b1;
`endif
        end
    end

    // Monitor: on every completed read, compare the head flit.
    always @(negedge clk_in) begin
        ent_t e;
        #1;
        if (rst_n_in && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_empty: got out_valid=1 expected no data to read (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", DW'(out_last), DW'(e.last));
            end
        end
    end

    // One cycle of stimulus, applied shortly after the rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        @(posedge clk_in);
        #2;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        mdl_err = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        do_reset();
        idle(2);

        // Fill to full, then read back in order.
        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        idle(1);
        drain(6);

        // Wrap-around of both pointers.
        for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i + 16), 1'b0, 1'b0);
        drain(3);
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(32'hA + i), 1'b0, 1'b0);
        drain(5);

        // Streaming at level 2.
        cycle(1'b1, DW'(32'h100), 1'b0, 1'b0);
        cycle(1'b1, DW'(32'h101), 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b1);
        drain(3);

        // Packet tracking.
        cycle(1'b1, DW'(32'h200), 1'b0, 1'b0);
        cycle(1'b1, DW'(32'h201), 1'b0, 1'b0);
        cycle(1'b1, DW'(32'h202), 1'b1, 1'b0);
        idle(2);
        drain(4);

        // Pushing into a full FIFO: writes dropped, flag behaviour per build.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(32'h300 + i), i == 4, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'hDEAD), 1'b1, 1'b0);
        idle(1);
        drain(6);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 10) < 6, rnd_data(), ($urandom % 4) == 0, ($urandom % 10) < 5);
        end
        drain(8);

        // Asynchronous reset with three flits stored.
        do_reset();
        idle(1);
        cycle(1'b1, DW'(32'h400), 1'b0, 1'b0);
        cycle(1'b1, DW'(32'h401), 1'b0, 1'b0);
        cycle(1'b1, DW'(32'h402), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_level", DW'(level), DW'(3));
        rst_n_in = 1'b0;
        exp_q.delete();
        mdl_err = 1'b0;
        #1;
        check("arst_out_valid", DW'(out_valid), DW'(0));
        check("arst_level",     DW'(level),     DW'(0));
        check("arst_pkt_avail", DW'(pkt_avail), DW'(0));
        repeat (2) @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
        idle(3);
        cycle(1'b1, DW'(32'h500), 1'b1, 1'b0);
        idle(1);
        drain(2);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
